// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core datapath and a
// word-addressed data memory that has no byte enables.
//
// Each core request is one of B, H, W, BU or HU. Sub-word stores are done
// as read-modify-write. Memory read data is valid on the second cycle of a
// held read request.
//
// Parameters:
//   ADDR_LIMIT : byte address bound; accesses at or above it are rejected
//   DATA_W     : data/address width (only 32 supported)
//
// Ports:
//   clk_i, rst_ni             : clock (rising edge), synchronous active-low reset
//   core_req_i                : request pulse, sampled in IDLE only
//   core_we_i / core_size_i   : store flag / RV funct3 access size
//   core_addr_i / core_wd_i   : byte address / store data
//   core_rd_o                 : extended load result, held until the next load
//   core_busy_o / core_done_o : busy while not IDLE / done pulse
//   core_err_o                : error flag, valid with done
//   mem_req_o, mem_we_o       : memory request / write enable
//   mem_addr_o, mem_wd_o      : word-aligned address / write data
//   mem_rd_i                  : memory read data
//   misalign_o                : misalignment error pulse (LSU_MISALIGN_TRAP_EN only)
//
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses are
// rejected instead of having their low address bits truncated.
module lsu_mem_master #(
  parameter int ADDR_LIMIT = 16384,
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [DATA_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_busy_o,
  output logic              core_done_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  input  logic [DATA_W-1:0] mem_rd_i
);

  localparam logic [DATA_W-1:0] LIMIT_C = DATA_W'(ADDR_LIMIT);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] merged_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic              size_ok;
  logic              range_ok;
  logic              mis_now;
  logic              reject;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              mis_q;
`endif

  // Select the byte/half lane of a read word and extend it to full width.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [2:0]        size,
                                                     input logic [1:0]        lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'b000:  return DATA_W'(b);
      3'b001:  return DATA_W'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Insert the low byte/half of the store data into the word read back.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        lane);
    logic [DATA_W-1:0] r;
    r = word;
    if (size[1:0] == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd[15:0];
    end else begin
      r[15:0] = wd[15:0];
    end
    return r;
  endfunction

  // Request qualification, evaluated against the live core inputs in IDLE.
  always_comb begin
    size_ok  = (core_size_i == 3'b000) || (core_size_i == 3'b001) ||
               (core_size_i == 3'b010) || (core_size_i == 3'b100) ||
               (core_size_i == 3'b101);
    range_ok = (core_addr_i < LIMIT_C);
`ifdef LSU_MISALIGN_TRAP_EN
    mis_now  = size_ok &&
               (((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00)));
`else
    mis_now  = 1'b0;
`endif
    reject   = !size_ok || !range_ok || mis_now;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_busy_o = (state != IDLE);
    core_done_o = 1'b0;
    core_err_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wd_o    = '0;
    case (state)
      IDLE: begin
        if (core_req_i) begin
          if (reject)                                  state_nxt = DONE;
          else if (core_we_i && core_size_i == 3'b010) state_nxt = WR;
          else                                         state_nxt = RD0;
        end
      end
      RD0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[DATA_W-1:2], 2'b00};
        state_nxt  = RD1;
      end
      RD1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[DATA_W-1:2], 2'b00};
        state_nxt  = we_q ? WR : DONE;
      end
      WR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {addr_q[DATA_W-1:2], 2'b00};
        mem_wd_o   = (size_q[1:0] == 2'b10) ? wd_q : merged_q;
        state_nxt  = DONE;
      end
      DONE: begin
        core_done_o = 1'b1;
        core_err_o  = err_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, read-data capture and merge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      merged_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            err_q  <= reject;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q  <= mis_now;
`endif
          end
        end
        RD1: begin
          if (we_q) merged_q <= store_merge(mem_rd_i, wd_q, size_q, addr_q[1:0]);
          else      rd_q     <= load_extract(mem_rd_i, size_q, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  assign core_rd_o = rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = (state == DONE) && mis_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a registered word-memory model.
module tb_lsu_mem_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_busy_o;
  logic        core_done_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  lsu_mem_master dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .core_req_i (core_req_i),
    .core_we_i  (core_we_i),
    .core_size_i(core_size_i),
    .core_addr_i(core_addr_i),
    .core_wd_i  (core_wd_i),
    .core_rd_o  (core_rd_o),
    .core_busy_o(core_busy_o),
    .core_done_o(core_done_o),
    .core_err_o (core_err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wd_o   (mem_wd_o),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_o (misalign_o),
`endif
    .mem_rd_i   (mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: read data registered, so it appears on the second req cycle.
  logic [31:0] mem [0:63];
  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o)  mem[mem_addr_o[7:2]] <= mem_wd_o;
    if (mem_req_o && !mem_we_o) mem_rd_i <= mem[mem_addr_o[7:2]];
  end

  typedef struct {
    logic        err;
    int          lat;
    logic [31:0] rd;
    int          nreq;
    logic        mis;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } wr_t;

  txn_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   failures = 0;
  int   lat_cnt = 0;
  int   req_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: pops the expected completion on done, and expected writes on WR.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      lat_cnt = 0;
      req_cnt = 0;
    end else begin
      if (core_busy_o) lat_cnt++;
      if (mem_req_o)   req_cnt++;
      if (mem_req_o && mem_we_o) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_addr_o, w.addr);
          check("wr_data", mem_wd_o, w.wd);
        end
      end
      if (core_done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          check("latency", 32'(lat_cnt), 32'(t.lat));
          check("err", {31'd0, core_err_o}, {31'd0, t.err});
          check("mem_req_cycles", 32'(req_cnt), 32'(t.nreq));
`ifdef LSU_MISALIGN_TRAP_EN
          check("misalign", {31'd0, misalign_o}, {31'd0, t.mis});
`endif
        end
        lat_cnt = 0;
        req_cnt = 0;
      end
    end
  end

  // core_rd_o is checked one cycle after done, once the register has settled.
  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic err, input int lat,
                        input logic [31:0] rd, input int nreq, input logic mis);
    txn_t t;
    t.err = err; t.lat = lat; t.rd = rd; t.nreq = nreq; t.mis = mis;
    exp_q.push_back(t);
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd;
    @(posedge clk_i); #1;
    core_req_i = 1'b0; core_wd_i = 32'h5A5A_5A5A; core_addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      if (!core_busy_o) break;
      @(posedge clk_i); #1;
    end
    if (core_busy_o) begin
      check("done_timeout", 32'd1, 32'd0);
      $fatal(1, "transaction never completed");
    end
    check("core_rd", core_rd_o, rd);
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] wd);
    wr_t w;
    w.addr = addr; w.wd = wd;
    wr_q.push_back(w);
  endtask

  initial begin
    rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
    core_addr_i = '0; core_wd_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", {31'd0, core_busy_o}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_done", {31'd0, core_done_o}, 32'd0);
    check("rst_rd", core_rd_o, 32'd0);
    rst_ni = 1'b1;

    // SW then LW
    exp_write(32'h10, 32'hDEADBEEF);
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2, 32'h0, 1, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 3, 32'hDEADBEEF, 2, 1'b0);

    // Preload words, then SB read-modify-write at byte lane 1
    exp_write(32'h20, 32'h11223344);
    do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 2, 32'hDEADBEEF, 1, 1'b0);
    exp_write(32'h30, 32'h80007FFF);
    do_req(1'b1, 3'b010, 32'h30, 32'h80007FFF, 1'b0, 2, 32'hDEADBEEF, 1, 1'b0);
    exp_write(32'h20, 32'h1122AA44);
    do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, 1'b0, 4, 32'hDEADBEEF, 3, 1'b0);
    do_req(1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 3, 32'hFFFFFFAA, 2, 1'b0);
    do_req(1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 3, 32'h000000AA, 2, 1'b0);

    // Half-word loads with sign/zero extension
    do_req(1'b0, 3'b001, 32'h32, 32'h0, 1'b0, 3, 32'hFFFF8000, 2, 1'b0);
    do_req(1'b0, 3'b101, 32'h32, 32'h0, 1'b0, 3, 32'h00008000, 2, 1'b0);
    do_req(1'b0, 3'b001, 32'h30, 32'h0, 1'b0, 3, 32'h00007FFF, 2, 1'b0);

    // Rejections: out of range and illegal size leave core_rd_o unchanged
    do_req(1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 1, 32'h00007FFF, 0, 1'b0);
    do_req(1'b0, 3'b011, 32'h30, 32'h0, 1'b1, 1, 32'h00007FFF, 0, 1'b0);
    do_req(1'b1, 3'b000, 32'h4001, 32'h0, 1'b1, 1, 32'h00007FFF, 0, 1'b0);

    // SH into the upper half, then read the word back
    exp_write(32'h30, 32'h12347FFF);
    do_req(1'b1, 3'b001, 32'h32, 32'hCAFE_1234, 1'b0, 4, 32'h00007FFF, 3, 1'b0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 3, 32'h12347FFF, 2, 1'b0);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 1'b1, 1, 32'h12347FFF, 0, 1'b1);
`else
    do_req(1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 3, 32'h1122AA44, 2, 1'b0);
`endif

    // Reset during RD1 of an LB: transaction abandoned, no done pulse
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b000; core_addr_i = 32'h21;
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("mid_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("mid_rst_busy", {31'd0, core_busy_o}, 32'd0);
    check("mid_rst_rd", core_rd_o, 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    check("pending_txn", 32'(exp_q.size()), 32'd0);
    check("pending_wr", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
